// File: rtl/tagged_reg_file.sv
// Register file x0..x31 where each entry carries a writer tag and a dirty bit for in-order scoreboarding.
// Optional macro TAGGED_RF_WB_BYPASS_EN forwards an accepted same-cycle write-back onto the read ports.
module tagged_reg_file #(
    parameter int unsigned TAG_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd_rf1_en,
    input  logic [4:0]           rd_rf1_addr,
    output logic [31:0]          rd_rf1_data,
    output logic [TAG_WIDTH-1:0] rd_rf1_tag,
    output logic                 rd_rf1_dirty,
    input  logic                 rd_rf2_en,
    input  logic [4:0]           rd_rf2_addr,
    output logic [31:0]          rd_rf2_data,
    output logic [TAG_WIDTH-1:0] rd_rf2_tag,
    output logic                 rd_rf2_dirty,
    input  logic                 alloc_en,
    input  logic [4:0]           alloc_addr,
    output logic [TAG_WIDTH-1:0] alloc_tag,
    input  logic                 wb_en,
    input  logic [4:0]           wb_addr,
    input  logic [TAG_WIDTH-1:0] wb_tag,
    input  logic [31:0]          wb_wdata,
    input  logic                 flush
);

    // Entry 0 exists only to keep indexing uniform; it is never written and never read out.
    logic [31:0]          data_q [32];
    logic [31:0]          data_d [32];
    logic [TAG_WIDTH-1:0] tag_q  [32];
    logic [TAG_WIDTH-1:0] tag_d  [32];
    logic [31:0]          dirty_q;
    logic [31:0]          dirty_d;

    logic wb_hit;
    logic alloc_hit;

    assign wb_hit    = wb_en && (wb_addr != '0) && dirty_q[wb_addr] && (wb_tag == tag_q[wb_addr]);
    assign alloc_hit = alloc_en && (alloc_addr != '0);
    assign alloc_tag = (alloc_addr == '0) ? '0 : tag_q[alloc_addr] + TAG_WIDTH'(1);

    // Write-back is applied before alloc so a same-register alloc overrides tag and dirty.
    always_comb begin
        data_d  = data_q;
        tag_d   = tag_q;
        dirty_d = dirty_q;
        if (flush) begin
            dirty_d = '0;
        end else begin
            if (wb_hit) begin
                data_d[wb_addr]  = wb_wdata;
                dirty_d[wb_addr] = 1'b0;
            end
            if (alloc_hit) begin
                tag_d[alloc_addr]   = alloc_tag;
                dirty_d[alloc_addr] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '{default: '0};
            tag_q   <= '{default: '0};
            dirty_q <= '0;
        end else begin
            data_q  <= data_d;
            tag_q   <= tag_d;
            dirty_q <= dirty_d;
        end
    end

`ifdef TAGGED_RF_WB_BYPASS_EN
    logic wb_fwd;
    assign wb_fwd = wb_hit && !flush && !rst;
`endif

    always_comb begin
        rd_rf1_data  = '0;
        rd_rf1_tag   = '0;
        rd_rf1_dirty = 1'b0;
        if (rd_rf1_en && (rd_rf1_addr != '0)) begin
            rd_rf1_data  = data_q[rd_rf1_addr];
            rd_rf1_tag   = tag_q[rd_rf1_addr];
            rd_rf1_dirty = dirty_q[rd_rf1_addr];
`ifdef TAGGED_RF_WB_BYPASS_EN
            if (wb_fwd && (wb_addr == rd_rf1_addr)) begin
                rd_rf1_data  = wb_wdata;
                rd_rf1_dirty = 1'b0;
            end
`endif
        end
    end

    always_comb begin
        rd_rf2_data  = '0;
        rd_rf2_tag   = '0;
        rd_rf2_dirty = 1'b0;
        if (rd_rf2_en && (rd_rf2_addr != '0)) begin
            rd_rf2_data  = data_q[rd_rf2_addr];
            rd_rf2_tag   = tag_q[rd_rf2_addr];
            rd_rf2_dirty = dirty_q[rd_rf2_addr];
`ifdef TAGGED_RF_WB_BYPASS_EN
            if (wb_fwd && (wb_addr == rd_rf2_addr)) begin
                rd_rf2_data  = wb_wdata;
                rd_rf2_dirty = 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_tagged_reg_file.sv
// Scoreboard bench for tagged_reg_file: directed scenarios then random traffic against a rule-level model.
module tb_tagged_reg_file;
    localparam int TW = 2;

    logic          clk = 1'b0;
    logic          rst, flush;
    logic          rd_rf1_en, rd_rf2_en, alloc_en, wb_en;
    logic [4:0]    rd_rf1_addr, rd_rf2_addr, alloc_addr, wb_addr;
    logic [31:0]   rd_rf1_data, rd_rf2_data, wb_wdata;
    logic [TW-1:0] rd_rf1_tag, rd_rf2_tag, alloc_tag, wb_tag;
    logic          rd_rf1_dirty, rd_rf2_dirty;

    always #5 clk = ~clk;

    tagged_reg_file #(.TAG_WIDTH(TW)) dut (
        .clk(clk), .rst(rst),
        .rd_rf1_en(rd_rf1_en), .rd_rf1_addr(rd_rf1_addr), .rd_rf1_data(rd_rf1_data),
        .rd_rf1_tag(rd_rf1_tag), .rd_rf1_dirty(rd_rf1_dirty),
        .rd_rf2_en(rd_rf2_en), .rd_rf2_addr(rd_rf2_addr), .rd_rf2_data(rd_rf2_data),
        .rd_rf2_tag(rd_rf2_tag), .rd_rf2_dirty(rd_rf2_dirty),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .alloc_tag(alloc_tag),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_tag(wb_tag), .wb_wdata(wb_wdata),
        .flush(flush)
    );

    typedef struct packed {
        logic          rst, flush;
        logic          rd1_en;  logic [4:0] rd1_addr;
        logic          rd2_en;  logic [4:0] rd2_addr;
        logic          al_en;   logic [4:0] al_addr;
        logic          wb_en;   logic [4:0] wb_addr;
        logic [TW-1:0] wb_tag;  logic [31:0] wb_data;
    } stim_t;

    typedef struct packed {
        logic [31:0] d1; logic [TW-1:0] t1; logic y1;
        logic [31:0] d2; logic [TW-1:0] t2; logic y2;
        logic [TW-1:0] at;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference state: architectural contents of x0..x31 as the rules describe them.
    logic [31:0] m_data  [32];
    int          m_tag   [32];
    bit          m_dirty [32];

    function automatic bit wb_accepted(stim_t s);
        return s.wb_en && s.wb_addr != 0 && m_dirty[s.wb_addr] && (int'(s.wb_tag) == m_tag[s.wb_addr]);
    endfunction

    function automatic void model_read(stim_t s, bit en, logic [4:0] a,
                                       output logic [31:0] d, output logic [TW-1:0] t, output logic y);
        d = 0; t = 0; y = 0;
        if (en && a != 0) begin
            d = m_data[a]; t = TW'(m_tag[a]); y = m_dirty[a];
`ifdef TAGGED_RF_WB_BYPASS_EN
            if (!s.rst && !s.flush && wb_accepted(s) && s.wb_addr == a) begin
                d = s.wb_data; y = 0;
            end
`endif
        end
    endfunction

    function automatic exp_t model_expect(stim_t s);
        exp_t e;
        model_read(s, s.rd1_en, s.rd1_addr, e.d1, e.t1, e.y1);
        model_read(s, s.rd2_en, s.rd2_addr, e.d2, e.t2, e.y2);
        e.at = (s.al_addr == 0) ? '0 : TW'((m_tag[s.al_addr] + 1) % (1 << TW));
        return e;
    endfunction

    function automatic void model_update(stim_t s);
        bit ok;
        int nt;
        if (s.rst) begin
            for (int i = 0; i < 32; i++) begin m_data[i] = 0; m_tag[i] = 0; m_dirty[i] = 0; end
        end else if (s.flush) begin
            for (int i = 0; i < 32; i++) m_dirty[i] = 0;
        end else begin
            ok = wb_accepted(s);
            nt = (m_tag[s.al_addr] + 1) % (1 << TW);
            if (ok) begin m_data[s.wb_addr] = s.wb_data; m_dirty[s.wb_addr] = 0; end
            if (s.al_en && s.al_addr != 0) begin m_tag[s.al_addr] = nt; m_dirty[s.al_addr] = 1; end
        end
    endfunction

    // One cycle: drive after the edge, queue the expectation, then advance the model across the edge.
    task automatic step(input stim_t s, input bit chk);
        rst = s.rst; flush = s.flush;
        rd_rf1_en = s.rd1_en; rd_rf1_addr = s.rd1_addr;
        rd_rf2_en = s.rd2_en; rd_rf2_addr = s.rd2_addr;
        alloc_en = s.al_en; alloc_addr = s.al_addr;
        wb_en = s.wb_en; wb_addr = s.wb_addr; wb_tag = s.wb_tag; wb_wdata = s.wb_data;
        if (chk) exp_q.push_back(model_expect(s));
        @(posedge clk);
        model_update(s);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("rd1_data",  rd_rf1_data,  e.d1);
            check("rd1_tag",   32'(rd_rf1_tag), 32'(e.t1));
            check("rd1_dirty", 32'(rd_rf1_dirty), 32'(e.y1));
            check("rd2_data",  rd_rf2_data,  e.d2);
            check("rd2_tag",   32'(rd_rf2_tag), 32'(e.t2));
            check("rd2_dirty", 32'(rd_rf2_dirty), 32'(e.y2));
            check("alloc_tag", 32'(alloc_tag), 32'(e.at));
        end
    end

    function automatic stim_t rd(logic [4:0] a);
        stim_t s = '0;
        s.rd1_en = 1; s.rd1_addr = a; s.rd2_en = 1; s.rd2_addr = a; s.al_addr = a;
        return s;
    endfunction

    function automatic stim_t al(logic [4:0] a);
        stim_t s = rd(a);
        s.al_en = 1;
        return s;
    endfunction

    function automatic stim_t wb(logic [4:0] a, logic [TW-1:0] t, logic [31:0] d);
        stim_t s = rd(a);
        s.wb_en = 1; s.wb_addr = a; s.wb_tag = t; s.wb_data = d;
        return s;
    endfunction

    initial begin
        stim_t s;
        s = '0; s.rst = 1;
        @(posedge clk); #1;
        step(s, 0);
        // x5: read after reset, alloc, matching write-back
        step(rd(5), 1);
        step(al(5), 1);
        step(wb(5, 2'd1, 32'hDEADBEEF), 1);
        step(rd(5), 1);
        // x7: stale write-back ignored, current one accepted
        step(al(7), 1);
        step(al(7), 1);
        step(wb(7, 2'd1, 32'h11), 1);
        step(wb(7, 2'd2, 32'h22), 1);
        step(rd(7), 1);
        step(wb(7, 2'd2, 32'h33), 1);
        step(rd(7), 1);
        // x3: tag wrap; x0 stays zero
        for (int i = 0; i < 4; i++) step(al(3), 1);
        step(rd(3), 1);
        s = wb(0, 2'd0, 32'hFF); s.al_en = 1;
        step(s, 1);
        step(rd(0), 1);
        // x9: simultaneous alloc and accepted write-back, then flush
        step(al(9), 1);
        step(al(9), 1);
        s = wb(9, 2'd2, 32'h55); s.al_en = 1;
        step(s, 1);
        step(rd(9), 1);
        s = rd(9); s.flush = 1; s.al_en = 1; s.wb_en = 1; s.wb_addr = 9; s.wb_tag = 2'd3;
        step(s, 1);
        step(rd(9), 1);
        // x4: read during write-back
        step(al(4), 1);
        step(wb(4, 2'd1, 32'hA5A5A5A5), 1);
        step(rd(4), 1);
        // reset mid-run: everything back to zero, alloc_tag=1
        s = rd(9); s.rst = 1; s.al_en = 1;
        step(s, 1);
        step(rd(9), 1);
        step(rd(0), 1);

        for (int n = 0; n < 400; n++) begin
            s = '0;
            s.rst      = ($urandom_range(0, 99) < 2);
            s.flush    = ($urandom_range(0, 99) < 5);
            s.rd1_en   = ($urandom_range(0, 9) != 0);
            s.rd1_addr = 5'($urandom_range(0, 7));
            s.rd2_en   = ($urandom_range(0, 9) != 0);
            s.rd2_addr = 5'($urandom_range(0, 7));
            s.al_en    = $urandom_range(0, 1) == 1;
            s.al_addr  = 5'($urandom_range(0, 7));
            s.wb_en    = $urandom_range(0, 1) == 1;
            s.wb_addr  = 5'($urandom_range(0, 7));
            s.wb_tag   = ($urandom_range(0, 9) < 7) ? TW'(m_tag[s.wb_addr]) : TW'($urandom);
            s.wb_data  = $urandom;
            step(s, 1);
        end

        @(negedge clk);
        if (exp_q.size() != 0) begin
            tests++; fails++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/tagged_reg_file.md
TAGGED_REG_FILE -- requirements
Module: tagged_reg_file

Interface
REQ-001 SHALL have parameter TAG_WIDTH, default 2, width of the per-register writer tag.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports rd_rf1_en/rd_rf2_en  input  1  read-port enables.
REQ-005 SHALL have ports rd_rf1_addr/rd_rf2_addr  input  5  read-port register indices.
REQ-006 SHALL have ports rd_rf1_data/rd_rf2_data  output  32  register value.
REQ-007 SHALL have ports rd_rf1_tag/rd_rf2_tag  output  TAG_WIDTH  current writer tag of the register.
REQ-008 SHALL have ports rd_rf1_dirty/rd_rf2_dirty  output  1  register has an outstanding writer.
REQ-009 SHALL have port alloc_en  input  1  issue stage claims a destination register.
REQ-010 SHALL have port alloc_addr  input  5  destination index.
REQ-011 SHALL have port alloc_tag  output  TAG_WIDTH  tag granted to the claiming instruction; carried down the pipe.
REQ-012 SHALL have ports wb_en (1), wb_addr (5), wb_tag (TAG_WIDTH), wb_wdata (32)  input  write-back from the final stage.
REQ-013 SHALL have port flush  input  1  pipeline kill; discard all outstanding writers.

Function
REQ-014 SHALL hold per register x1..x31: data[31:0], tag[TAG_WIDTH-1:0], dirty.
REQ-015 SHALL read combinationally: with rd_rfN_en=1, outputs reflect the addressed entry's registered state; with en=0, data/tag/dirty SHALL be 0.
REQ-016 SHALL return data=0, tag=0, dirty=0 for address 0 regardless of history.
REQ-017 SHALL drive alloc_tag = tag[alloc_addr]+1 modulo 2^TAG_WIDTH, combinationally; 0 when alloc_addr=0.
REQ-018 SHALL on alloc_en=1, alloc_addr!=0: tag<=alloc_tag, dirty<=1 at the next edge.
REQ-019 SHALL on wb_en=1, wb_addr!=0, wb_tag==tag[wb_addr], dirty=1: data<=wb_wdata, dirty<=0.
REQ-020 SHALL ignore a write-back whose tag mismatches (stale writer superseded) or whose target is clean; no state change.
REQ-021 SHALL, on simultaneous alloc and accepted write-back to the same register: write data, set tag to alloc_tag, and leave dirty=1 (alloc wins dirty).
REQ-022 SHALL treat write-backs/allocs to different registers in the same cycle independently.
REQ-023 SHALL, on flush=1: clear every dirty bit at the next edge, keep data and tags; alloc_en and wb_en in that cycle are ignored.
REQ-024 SHALL wrap tags from 2^TAG_WIDTH-1 to 0; pipeline guarantees fewer than 2^TAG_WIDTH outstanding writers per register.
REQ-025 SHALL read pre-edge state in the same cycle as a write (no internal read-during-write bypass) unless REQ-029 applies.

Reset
REQ-026 SHALL on rst=1 clear all data, tags, dirty bits to 0 at the next edge, overriding flush, alloc and write-back.
REQ-027 SHALL output, one cycle after reset asserts, rd data/tag/dirty=0 for any address and alloc_tag=1 for any nonzero alloc_addr.

Configuration
REQ-028 SHALL recognise macro TAGGED_RF_WB_BYPASS_EN.
REQ-029 SHALL, with TAGGED_RF_WB_BYPASS_EN defined, make a read port whose address matches an accepted (REQ-019) same-cycle write-back return data=wb_wdata and dirty=0; tag unchanged.
REQ-030 SHALL, without the macro, behave per REQ-025; relies on the external forwarding path.

Verification
REQ-031 reset, read x5 -> data=0, tag=0, dirty=0; alloc x5 -> alloc_tag=1, next cycle dirty=1, tag=1.
REQ-032 alloc x5 (tag 1), wb x5 tag 1 data 0xDEADBEEF -> next cycle data=0xDEADBEEF, dirty=0.
REQ-033 alloc x7 twice (tags 1,2), wb x7 tag 1 data 0x11 -> ignored, dirty=1; wb tag 2 data 0x22 -> data=0x22, dirty=0.
REQ-034 alloc x3 four times from reset -> tags 1,2,3,0 (wrap); alloc x0 and wb x0 data 0xFF -> x0 reads 0.
REQ-035 x9 dirty with tag 2, same cycle alloc x9 and wb x9 tag 2 data 0x55 -> data=0x55, tag=3, dirty=1; then flush -> dirty=0, data=0x55, tag=3.
REQ-036 with macro: wb x4 tag-match data 0xA5A5A5A5 and read x4 same cycle -> data=0xA5A5A5A5, dirty=0; without macro -> old data, dirty=1.
